card_dealer: RTL and testbench
==============================

# card_dealer

Draws cards without replacement from a single 52-card deck for the BlackJack game controller. On a deal request it pulls values from the upstream random number generator, rejects out-of-range or already-dealt indices, and falls back to a bounded linear probe so every deal terminates. It returns one card per request as rank, suit and BlackJack point value, and tracks the number of cards remaining.

## Interface
- RAND_WIDTH, 6, width of random input; must be ≥ 6
- MAX_RETRIES, 8, rejected random draws before switching to linear probe; range 1..255
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- new_deck  in  1  restore all 52 cards (honoured in any state)
- deal_req  in  1  request one card; sampled only in IDLE
- rand_value  in  RAND_WIDTH  value from random number generator
- rand_request  out  1  request to random number generator
- card_valid  out  1  one-cycle pulse: card outputs hold a new card
- card_rank  out  4  1 (ace) .. 13 (king)
- card_suit  out  2  0..3
- card_points  out  4  ace 11, 2..10 face value, J/Q/K 10
- cards_left  out  6  0..52
- deck_empty  out  1  cards_left == 0
- busy  out  1  state != IDLE

## Operation
- Card index i in 0..51: suit = i / 13, rank = i % 13 + 1.
- 52-bit used mask; bit i set means card i already dealt.
- States: IDLE, FETCH, CHECK, PROBE, DEAL.
- IDLE: deal_req && !deck_empty → FETCH, retry counter cleared. deal_req while deck_empty is ignored; no card_valid.
- FETCH: rand_request = 1; rand_value[5:0] captured into candidate at the clock edge; upper bits above bit 5 ignored. → CHECK.
- CHECK: candidate < 52 and unused → DEAL. Otherwise retry counter increments; if the new count == MAX_RETRIES → PROBE with candidate = (candidate ≥ 52 ? 0 : candidate + 1, 51 wraps to 0), else → FETCH.
- PROBE: candidate unused → DEAL; else candidate increments, 51 wraps to 0. Terminates because deck_empty = 0.
- DEAL: set used[candidate]; cards_left decrements; card_rank, card_suit and card_points registered from candidate; card_valid = 1 this cycle; → IDLE.
- new_deck, in any state: mask cleared, cards_left = 52, state → IDLE, pending deal aborted with no card_valid. If asserted together with deal_req, new_deck wins and deal_req is dropped; the requester re-asserts.
- deal_req asserted while busy is ignored and not queued.

## Timing
- Reset values: card_valid 0, rand_request 0, card_rank/card_suit/card_points 0, cards_left 52, deck_empty 0, busy 0, mask cleared, state IDLE.
- Card outputs are registered. They change only on DEAL and hold between deals.
- Minimum latency: deal_req sampled at edge N; FETCH in cycle N+1, CHECK N+2, DEAL/card_valid N+3.
- Each rejected draw before the limit adds 2 cycles. Each probe step adds 1 cycle.
- Worst case: 3 + 2·(MAX_RETRIES−1) + 1 + 51 cycles.
- deck_empty and cards_left update in the cycle after DEAL.
- rand_request is high only in FETCH, exactly one cycle per draw.
- Reset mid-deal: next cycle IDLE, card_valid 0, full deck restored.

## Structure
- Shared package blackjack_pkg holds:
  - DECK_SIZE = 52 and CARDS_PER_SUIT = 13
  - card_index_t (6-bit) and suit_t enum (HEARTS, DIAMONDS, CLUBS, SPADES)
  - dealer_state_t enum
  - function card_points(rank)
- One sub-module, card_decoder: combinational index → rank/suit/points. It is reused by display logic.
- The mask, counters and FSM live in card_dealer.

## Test plan
- Reset, then deal_req with rand_value = 0 → card_valid at +3 cycles with rank 1, suit 0, points 11; cards_left 51.
- rand_value = 60 then 25 → one retry; card at +5 cycles with rank 13, suit 1, points 10.
- MAX_RETRIES = 2; card 51 dealt, then rand_value held at 51 → after 2 rejects, probe wraps to index 0 → rank 1, suit 0.
- 52 deals with bench-driven random values → 52 distinct cards, deck_empty = 1 after the last. 53rd deal_req → no card_valid, busy stays 0.
- new_deck asserted in CHECK → state IDLE next cycle, no card_valid, cards_left 52. new_deck + deal_req in the same cycle → no deal.
- Reset asserted during PROBE → all outputs at reset values next cycle; a subsequent deal succeeds in 3 cycles.

Source files
------------

// File: rtl/blackjack_pkg.sv
// blackjack_pkg: deck constants, card types, dealer states and point helper shared by the BlackJack blocks.
package blackjack_pkg;
    localparam int DECK_SIZE = 52;
    localparam int CARDS_PER_SUIT = 13;
    typedef logic [5:0] card_index_t;
    localparam card_index_t LAST_CARD = 6'(DECK_SIZE - 1);
    typedef enum logic [1:0] {HEARTS, DIAMONDS, CLUBS, SPADES} suit_t;
    typedef enum logic [2:0] {IDLE, FETCH, CHECK, PROBE, DEAL} dealer_state_t;
    function automatic logic [3:0] card_points(input logic [3:0] rank);
        return rank == 4'd1 ? 4'd11 : rank > 4'd10 ? 4'd10 : rank;
    endfunction
endpackage

// File: rtl/card_decoder.sv
// card_decoder: combinational card index to rank, suit and BlackJack point value.
module card_decoder
    import blackjack_pkg::*;
(
    input  card_index_t index_i,
    output logic [3:0]  rank_o,
    output suit_t       suit_o,
    output logic [3:0]  points_o
);
    logic [5:0] base;
    always_comb begin
        base = index_i >= 6'd39 ? 6'd39 : index_i >= 6'd26 ? 6'd26 : index_i >= 6'd13 ? 6'd13 : 6'd0;
        suit_o = index_i >= 6'd39 ? SPADES : index_i >= 6'd26 ? CLUBS : index_i >= 6'd13 ? DIAMONDS : HEARTS;
        rank_o = 4'(index_i - base + 6'd1);
        points_o = card_points(rank_o);
    end
endmodule

// File: rtl/card_dealer.sv
// card_dealer: draws cards without replacement from one deck using random draws with a bounded linear-probe fallback.
module card_dealer
    import blackjack_pkg::*;
#(
    parameter int RAND_WIDTH = 6,
    parameter int MAX_RETRIES = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  new_deck_i,
    input  logic                  deal_req_i,
    input  logic [RAND_WIDTH-1:0] rand_value_i,
    output logic                  rand_request_o,
    output logic                  card_valid_o,
    output logic [3:0]            card_rank_o,
    output logic [1:0]            card_suit_o,
    output logic [3:0]            card_points_o,
    output logic [5:0]            cards_left_o,
    output logic                  deck_empty_o,
    output logic                  busy_o
);
    dealer_state_t state_q, state_d;
    card_index_t   cand_q, cand_d, nxt_idx;
    logic [7:0]    retry_q, retry_d;
    logic [51:0]   used_q;
    logic [5:0]    left_q;
    logic [3:0]    rank_q, points_q, dec_rank, dec_points;
    logic [1:0]    suit_q;
    suit_t         dec_suit;
    logic          hit;

    card_decoder u_dec (
        .index_i (cand_q),
        .rank_o  (dec_rank),
        .suit_o  (dec_suit),
        .points_o(dec_points)
    );

    assign nxt_idx = cand_q >= LAST_CARD ? '0 : cand_q + 6'd1;
    assign hit = cand_q <= LAST_CARD && !used_q[cand_q];

    always_comb begin
        state_d = state_q;
        cand_d = cand_q;
        retry_d = retry_q;
        case (state_q)
            IDLE: if (deal_req_i && !deck_empty_o) begin
                state_d = FETCH;
                retry_d = '0;
            end
            FETCH: begin
                cand_d = rand_value_i[5:0];
                state_d = CHECK;
            end
            CHECK: if (hit) state_d = DEAL;
            else begin
                retry_d = retry_q + 8'd1;
                state_d = retry_d == 8'(MAX_RETRIES) ? PROBE : FETCH;
                cand_d = retry_d == 8'(MAX_RETRIES) ? nxt_idx : cand_q;
            end
            PROBE: if (hit) state_d = DEAL;
            else cand_d = nxt_idx;
            default: state_d = IDLE;
        endcase
        if (new_deck_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cand_q <= '0;
            retry_q <= '0;
            used_q <= '0;
            left_q <= 6'(DECK_SIZE);
            rank_q <= '0;
            suit_q <= '0;
            points_q <= '0;
        end else begin
            state_q <= state_d;
            cand_q <= cand_d;
            retry_q <= retry_d;
            if (new_deck_i) begin
                used_q <= '0;
                left_q <= 6'(DECK_SIZE);
            end else if (state_q == DEAL) begin
                used_q[cand_q] <= 1'b1;
                left_q <= left_q - 6'd1;
            end
            // Load the card as DEAL is entered so it is visible alongside card_valid.
            if (state_d == DEAL) begin
                rank_q <= dec_rank;
                suit_q <= dec_suit;
                points_q <= dec_points;
            end
        end
    end

    assign rand_request_o = state_q == FETCH;
    assign card_valid_o = state_q == DEAL;
    assign card_rank_o = rank_q;
    assign card_suit_o = suit_q;
    assign card_points_o = points_q;
    assign cards_left_o = left_q;
    assign deck_empty_o = left_q == 6'd0;
    assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: randomized and directed deals checked against a deck-level reference model.
module tb_card_dealer;
    localparam int MAXR = 2;
    logic       clk = 0;
    logic       reset = 1, new_deck = 0, deal_req = 0;
    logic [5:0] rand_value = '0;
    logic       rand_request, card_valid, deck_empty, busy;
    logic [3:0] card_rank, card_points;
    logic [1:0] card_suit;
    logic [5:0] cards_left;
    int checks = 0, failures = 0;
    int rq[$], drawn[$];
    bit mused[52];
    int mleft = 52;

    card_dealer #(.RAND_WIDTH(6), .MAX_RETRIES(MAXR)) dut (
        .clk_i(clk), .reset_i(reset), .new_deck_i(new_deck), .deal_req_i(deal_req),
        .rand_value_i(rand_value), .rand_request_o(rand_request), .card_valid_o(card_valid),
        .card_rank_o(card_rank), .card_suit_o(card_suit), .card_points_o(card_points),
        .cards_left_o(cards_left), .deck_empty_o(deck_empty), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        foreach (mused[i]) mused[i] = 0;
        mleft = 52;
    endfunction

    // Expected card and latency from the values actually handed to the dealer.
    function automatic void model_pick(output int idx, output int cyc);
        int k = 0;
        int p, s;
        idx = -1;
        cyc = 0;
        foreach (drawn[j]) begin
            if (drawn[j] < 52 && !mused[drawn[j]]) begin
                idx = drawn[j];
                cyc = 3 + 2 * k;
                return;
            end
            k++;
            if (k == MAXR) begin
                p = drawn[j] >= 51 ? 0 : drawn[j] + 1;
                s = 0;
                while (mused[p] && s < 52) begin
                    p = (p + 1) % 52;
                    s++;
                end
                idx = p;
                cyc = 2 * MAXR + 2 + s;
                return;
            end
        end
    endfunction

    task automatic feed();
        if (rand_request) begin
            if (rq.size() > 0) rand_value = 6'(rq.pop_front());
            else rand_value = 6'($urandom_range(0, 63));
            drawn.push_back(int'(rand_value));
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({card_valid, rand_request, card_rank, card_suit, card_points, deck_empty, busy} !== 17'd0 || cards_left !== 6'd52) begin
            failures++;
            $display("FAIL %s: valid=%0b req=%0b rank=%0d suit=%0d pts=%0d left=%0d empty=%0b busy=%0b, want all 0 and left=52",
                     tag, card_valid, rand_request, card_rank, card_suit, card_points, cards_left, deck_empty, busy);
        end
    endtask

    task automatic deal(output int cyc);
        int ei, ec, er, es, ep;
        drawn.delete();
        deal_req = 1;
        @(negedge clk);
        deal_req = 0;
        cyc = 1;
        feed();
        while (!card_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
            feed();
        end
        checks++;
        if (!card_valid) begin
            failures++;
            $display("FAIL deal_timeout: card_valid=0 after %0d cycles, want 1", cyc);
        end
        model_pick(ei, ec);
        er = ei % 13 + 1;
        es = ei / 13;
        ep = er == 1 ? 11 : (er > 10 ? 10 : er);
        checks++;
        if (cyc != ec) begin
            failures++;
            $display("FAIL deal_latency: got %0d cycles, want %0d", cyc, ec);
        end
        checks++;
        if (card_rank !== 4'(er) || card_suit !== 2'(es) || card_points !== 4'(ep)) begin
            failures++;
            $display("FAIL deal_card: got rank=%0d suit=%0d pts=%0d, want rank=%0d suit=%0d pts=%0d",
                     card_rank, card_suit, card_points, er, es, ep);
        end
        if (ei >= 0) begin
            mused[ei] = 1;
            mleft--;
        end
        @(negedge clk);
        checks++;
        if (card_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL deal_pulse: got valid=%0b busy=%0b after deal, want 0 0", card_valid, busy);
        end
        checks++;
        if (cards_left !== 6'(mleft) || deck_empty !== (mleft == 0)) begin
            failures++;
            $display("FAIL deal_count: got left=%0d empty=%0b, want left=%0d empty=%0b", cards_left, deck_empty, mleft, mleft == 0);
        end
    endtask

    task automatic pulse_new_deck();
        new_deck = 1;
        @(negedge clk);
        new_deck = 0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        check_reset_values("reset_state");
    endtask

    task automatic test_first_card();
        int c;
        rq = '{0};
        deal(c);
        checks++;
        if (c != 3 || card_rank !== 4'd1 || card_points !== 4'd11 || cards_left !== 6'd51) begin
            failures++;
            $display("FAIL first_card: got cyc=%0d rank=%0d pts=%0d left=%0d, want 3 1 11 51", c, card_rank, card_points, cards_left);
        end
    endtask

    task automatic test_retry();
        int c;
        rq = '{60, 25};
        deal(c);
        checks++;
        if (c != 5 || card_rank !== 4'd13 || card_suit !== 2'd1 || card_points !== 4'd10) begin
            failures++;
            $display("FAIL retry: got cyc=%0d rank=%0d suit=%0d pts=%0d, want 5 13 1 10", c, card_rank, card_suit, card_points);
        end
    endtask

    task automatic test_probe_wrap();
        int c;
        pulse_new_deck();
        rq = '{51};
        deal(c);
        rq = '{51, 51};
        deal(c);
        checks++;
        if (card_rank !== 4'd1 || card_suit !== 2'd0 || c != 6) begin
            failures++;
            $display("FAIL probe_wrap: got rank=%0d suit=%0d cyc=%0d, want 1 0 6", card_rank, card_suit, c);
        end
    endtask

    task automatic test_full_deck();
        int c, di, dups = 0;
        bit seen[52];
        pulse_new_deck();
        rq.delete();
        for (int i = 0; i < 52; i++) begin
            deal(c);
            di = int'(card_suit) * 13 + int'(card_rank) - 1;
            if (di < 0 || di > 51 || seen[di]) dups++;
            else seen[di] = 1;
        end
        checks++;
        if (dups != 0 || deck_empty !== 1'b1 || cards_left !== 6'd0) begin
            failures++;
            $display("FAIL full_deck: got dups=%0d empty=%0b left=%0d, want 0 1 0", dups, deck_empty, cards_left);
        end
        deal_req = 1;
        @(negedge clk);
        deal_req = 0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (card_valid !== 1'b0 || busy !== 1'b0 || rand_request !== 1'b0) begin
                failures++;
                $display("FAIL empty_deal: got valid=%0b busy=%0b req=%0b, want 0 0 0", card_valid, busy, rand_request);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_new_deck_abort();
        int c;
        pulse_new_deck();
        rq = '{5};
        deal(c);
        rq = '{20};
        drawn.delete();
        deal_req = 1;
        @(negedge clk);
        deal_req = 0;
        feed();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy: got busy=%0b in check step, want 1", busy);
        end
        new_deck = 1;
        @(negedge clk);
        new_deck = 0;
        model_reset();
        checks++;
        if (busy !== 1'b0 || card_valid !== 1'b0 || cards_left !== 6'd52 || card_rank !== 4'd6) begin
            failures++;
            $display("FAIL abort: got busy=%0b valid=%0b left=%0d rank=%0d, want 0 0 52 6", busy, card_valid, cards_left, card_rank);
        end
        new_deck = 1;
        deal_req = 1;
        @(negedge clk);
        new_deck = 0;
        deal_req = 0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (card_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL newdeck_with_req: got valid=%0b busy=%0b, want 0 0", card_valid, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_probe();
        int c;
        pulse_new_deck();
        for (int i = 0; i < 10; i++) begin
            rq = '{i};
            deal(c);
        end
        rq = '{0, 0};
        drawn.delete();
        deal_req = 1;
        @(negedge clk);
        deal_req = 0;
        for (int i = 1; i < 5; i++) begin
            feed();
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b1 || rand_request !== 1'b0 || card_valid !== 1'b0) begin
            failures++;
            $display("FAIL probe_entry: got busy=%0b req=%0b valid=%0b, want 1 0 0", busy, rand_request, card_valid);
        end
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
        check_reset_values("reset_in_probe");
        rq = '{7};
        deal(c);
        checks++;
        if (c != 3 || card_rank !== 4'd8) begin
            failures++;
            $display("FAIL deal_after_reset: got cyc=%0d rank=%0d, want 3 8", c, card_rank);
        end
    endtask

    task automatic test_random_deals();
        int c;
        pulse_new_deck();
        for (int i = 0; i < 20; i++) begin
            rq.delete();
            for (int k = 0; k < 3; k++) rq.push_back($urandom_range(0, 63));
            deal(c);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_card();
        test_retry();
        test_probe_wrap();
        test_full_deck();
        test_new_deck_abort();
        test_reset_in_probe();
        test_random_deals();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
